// File: rtl/loader_pkg.sv
// Shared state type and word/address geometry for the program loader.
// Build option LOADER_CHECKSUM_EN adds the CHECK state for the trailing XOR byte.
package loader_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int ADDR_STRIDE    = 4;
   localparam int WORD_W         = BYTES_PER_WORD * 8;

   typedef enum logic [2:0] {
      IDLE,
      RECV,
      WRITE,
`ifdef LOADER_CHECKSUM_EN
      CHECK,
`endif
      FINISH
   } state_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader takes the slave side; the byte source / memory model takes the master side.
interface program_loader_if;

   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        initialize;
   logic [31:0] instruction_initialize_data;
   logic [31:0] instruction_initialize_address;

   modport master (
      output in_valid, in_data,
      input  in_ready, initialize, instruction_initialize_data, instruction_initialize_address
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, initialize, instruction_initialize_data, instruction_initialize_address
   );

endinterface

// File: rtl/word_assembler.sv
// Packs accepted bytes little-endian into a word; word_valid_o flags the byte
// that completes the word (the full word is on word_o from the next cycle).
module word_assembler
   import loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              byte_valid_i,
   input  logic [7:0]        byte_i,
   output logic [WORD_W-1:0] word_o,
   output logic              word_valid_o
);

   localparam int CW = $clog2(BYTES_PER_WORD);

   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WORD_W-1:0] shift_q, shift_d;

   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      if (clear_i) begin
         cnt_d   = '0;
         shift_d = '0;
      end else if (byte_valid_i) begin
         cnt_d   = cnt_q + 1'b1;
         // Newest byte enters at the top, so the first byte ends up in [7:0].
         shift_d = {byte_i, shift_q[WORD_W-1:8]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         shift_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
      end
   end

   assign word_o       = shift_q;
   assign word_valid_o = byte_valid_i && (cnt_q == CW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Streams a program byte-wise into CPU instruction memory, holding the CPU in reset meanwhile.
// Build option LOADER_CHECKSUM_EN: verify a trailing XOR byte after the last word.
module program_loader
   import loader_pkg::*;
#(
   parameter int          MAX_WORDS = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [7:0]       load_len_i,
   program_loader_if.slave  bus,
   output logic             cpu_rst_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             error_o
);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  len_q, len_d;
   logic        error_q, error_d;
   logic        cpu_rst_q, cpu_rst_d;
   logic        xfer, asm_clear, word_valid;
   logic [31:0] word;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  xor_q, xor_d;
`endif

   assign xfer = bus.in_valid && bus.in_ready;

   word_assembler u_word_assembler (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (asm_clear),
      .byte_valid_i (xfer && (state_q == RECV)),
      .byte_i       (bus.in_data),
      .word_o       (word),
      .word_valid_o (word_valid)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      error_d   = error_q;
      cpu_rst_d = cpu_rst_q;
      asm_clear = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_d     = xor_q;
`endif
      case (state_q)
         IDLE: begin
            if (start_i) begin
               cpu_rst_d = 1'b1;
               len_d     = load_len_i;
               error_d   = 1'b0;
               asm_clear = 1'b1;
`ifdef LOADER_CHECKSUM_EN
               xor_d     = '0;
`endif
               if (load_len_i == 8'd0) begin
                  state_d = FINISH;
               end else if (int'(load_len_i) > MAX_WORDS) begin
                  error_d = 1'b1;
                  state_d = FINISH;
               end else begin
                  state_d = RECV;
                  cnt_d   = '0;
                  addr_d  = BASE_ADDR;
               end
            end
         end
         RECV: begin
            if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
               xor_d = xor_q ^ bus.in_data;
`endif
               if (word_valid) state_d = WRITE;
            end
         end
         WRITE: begin
            addr_d = addr_q + 32'(ADDR_STRIDE);
            cnt_d  = cnt_q + 8'd1;
            if (cnt_q + 8'd1 == len_q) begin
`ifdef LOADER_CHECKSUM_EN
               state_d = CHECK;
`else
               state_d = FINISH;
`endif
            end else begin
               state_d = RECV;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CHECK: begin
            if (xfer) begin
               if (bus.in_data != xor_q) error_d = 1'b1;
               state_d = FINISH;
            end
         end
`endif
         FINISH: begin
            // A failed load keeps the CPU parked in reset.
            cpu_rst_d = error_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         cnt_q     <= '0;
         len_q     <= '0;
         error_q   <= 1'b0;
         cpu_rst_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
         xor_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         error_q   <= error_d;
         cpu_rst_q <= cpu_rst_d;
`ifdef LOADER_CHECKSUM_EN
         xor_q     <= xor_d;
`endif
      end
   end

   always_comb begin
      bus.in_ready = (state_q == RECV);
`ifdef LOADER_CHECKSUM_EN
      if (state_q == CHECK) bus.in_ready = 1'b1;
`endif
   end

   assign bus.initialize                     = (state_q == WRITE);
   assign bus.instruction_initialize_data    = word;
   assign bus.instruction_initialize_address = addr_q;
   assign busy_o    = (state_q != IDLE) && (state_q != FINISH);
   assign done_o    = (state_q == FINISH);
   assign error_o   = error_q;
   assign cpu_rst_o = cpu_rst_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed spec scenarios plus randomized loads
// compared against a word-list model of the expected instruction-memory writes.
module tb_program_loader;

   localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef LOADER_CHECKSUM_EN
   localparam int CHK = 1;
`else
   localparam int CHK = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       start_i;
   logic [7:0] load_len_i;
   logic       cpu_rst_o, busy_o, done_o, error_o;

   program_loader_if bus ();

   program_loader #(.MAX_WORDS(64), .BASE_ADDR(BASE)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .load_len_i (load_len_i),
      .bus        (bus),
      .cpu_rst_o  (cpu_rst_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .error_o    (error_o)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  stim_q[$];
   logic [31:0] model_words[$];
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          ready_viol = 0;

   // Observed memory writes; the checks live in the tests.
   always @(negedge clk) begin
      if (bus.initialize === 1'b1) begin
         wr_addr_q.push_back(bus.instruction_initialize_address);
         wr_data_q.push_back(bus.instruction_initialize_data);
         if (bus.in_ready !== 1'b0) ready_viol++;
      end
   end

   // Model: each word becomes 4 bytes, least significant first, then optional XOR byte.
   function automatic void build_stream();
      logic [7:0] x;
      logic [31:0] w;
      x = 8'h00;
      stim_q.delete();
      foreach (model_words[i]) begin
         w = model_words[i];
         for (int b = 0; b < 4; b++) begin
            stim_q.push_back(8'((w >> (8 * b)) & 32'hFF));
            x = x ^ 8'((w >> (8 * b)) & 32'hFF);
         end
      end
      if (CHK == 1) stim_q.push_back(x);
   endfunction

   task automatic run_load(input int len, input int gap_pct, input bit noisy,
                           output int done_cyc, output logic err_done,
                           output logic cr_done, output logic cr_after);
      int idx = 0;
      int cyc = 0;
      bit fin = 0;
      bit pend;
      wr_addr_q.delete();
      wr_data_q.delete();
      ready_viol = 0;
      done_cyc = -1;
      err_done = 1'bx;
      cr_done  = 1'bx;
      @(negedge clk);
      start_i    = 1'b1;
      load_len_i = 8'(len);
      bus.in_valid = (stim_q.size() > 0);
      bus.in_data  = (stim_q.size() > 0) ? stim_q[0] : 8'h00;
      pend = bus.in_valid && bus.in_ready;
      while (!fin && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (pend) idx++;
         if (done_o === 1'b1) begin
            done_cyc = cyc;
            err_done = error_o;
            cr_done  = cpu_rst_o;
            fin = 1;
         end
         start_i = noisy && !fin && ($urandom_range(3) == 0);
         if (start_i) load_len_i = 8'($urandom_range(255));
         if (!fin && idx < stim_q.size() && $urandom_range(99) >= gap_pct) begin
            bus.in_valid = 1'b1;
            bus.in_data  = stim_q[idx];
         end else begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom_range(255));
         end
         pend = bus.in_valid && bus.in_ready;
      end
      @(negedge clk);
      start_i      = 1'b0;
      bus.in_valid = 1'b0;
      cr_after = cpu_rst_o;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start_i = 1'b0;
      load_len_i = 8'd0;
      bus.in_valid = 1'b0;
      bus.in_data = 8'h00;
      repeat (2) @(negedge clk);
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset in_ready: got %b want 0", bus.in_ready); end
      n_cmp++; if (bus.initialize !== 1'b0) begin n_bad++; $display("FAIL reset initialize: got %b want 0", bus.initialize); end
      n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", busy_o); end
      n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL reset done: got %b want 0", done_o); end
      n_cmp++; if (error_o !== 1'b0) begin n_bad++; $display("FAIL reset error: got %b want 0", error_o); end
      n_cmp++; if (cpu_rst_o !== 1'b1) begin n_bad++; $display("FAIL reset cpu_rst: got %b want 1", cpu_rst_o); end
      n_cmp++; if (bus.instruction_initialize_data !== 32'h0) begin n_bad++; $display("FAIL reset data: got %h want 0", bus.instruction_initialize_data); end
      n_cmp++; if (bus.instruction_initialize_address !== 32'h0) begin n_bad++; $display("FAIL reset address: got %h want 0", bus.instruction_initialize_address); end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (cpu_rst_o !== 1'b1 || busy_o !== 1'b0) begin n_bad++; $display("FAIL post_reset idle: cpu_rst=%b busy=%b want 1/0", cpu_rst_o, busy_o); end
      $display("reset: checked outputs in and after reset");
   endtask

   task automatic test_directed();
      int dc; logic ed, cd, ca;
      logic [7:0] x;
      stim_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      x = 8'h00;
      foreach (stim_q[i]) x = x ^ stim_q[i];
      if (CHK == 1) stim_q.push_back(x);
      run_load(2, 0, 0, dc, ed, cd, ca);
      n_cmp++; if (wr_addr_q.size() != 2) begin n_bad++; $display("FAIL directed write_count: got %0d want 2", wr_addr_q.size()); end
      else begin
         n_cmp++; if (wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== 32'h12345678) begin n_bad++; $display("FAIL directed write0: got (%h,%h) want (0,12345678)", wr_addr_q[0], wr_data_q[0]); end
         n_cmp++; if (wr_addr_q[1] !== 32'h4 || wr_data_q[1] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL directed write1: got (%h,%h) want (4,deadbeef)", wr_addr_q[1], wr_data_q[1]); end
      end
      n_cmp++; if (dc != 11 + CHK) begin n_bad++; $display("FAIL directed done_cycle: got %0d want %0d", dc, 11 + CHK); end
      n_cmp++; if (ed !== 1'b0) begin n_bad++; $display("FAIL directed error: got %b want 0", ed); end
      n_cmp++; if (cd !== 1'b1 || ca !== 1'b0) begin n_bad++; $display("FAIL directed cpu_rst: at done %b after %b want 1/0", cd, ca); end
      $display("directed: 2-word load, %0d writes, done at cycle %0d", wr_addr_q.size(), dc);
   endtask

   task automatic test_too_long();
      int dc; logic ed, cd, ca;
      stim_q.delete();
      run_load(65, 0, 0, dc, ed, cd, ca);
      n_cmp++; if (dc != 1) begin n_bad++; $display("FAIL too_long done_cycle: got %0d want 1", dc); end
      n_cmp++; if (ed !== 1'b1) begin n_bad++; $display("FAIL too_long error: got %b want 1", ed); end
      n_cmp++; if (wr_addr_q.size() != 0) begin n_bad++; $display("FAIL too_long writes: got %0d want 0", wr_addr_q.size()); end
      n_cmp++; if (ca !== 1'b1) begin n_bad++; $display("FAIL too_long cpu_rst_after: got %b want 1", ca); end
      n_cmp++; if (error_o !== 1'b1) begin n_bad++; $display("FAIL too_long error_sticky: got %b want 1", error_o); end
      $display("too_long: len=65 error=%b done at cycle %0d", ed, dc);
   endtask

   task automatic test_zero_len();
      int dc; logic ed, cd, ca;
      stim_q.delete();
      run_load(0, 0, 0, dc, ed, cd, ca);
      n_cmp++; if (dc != 1) begin n_bad++; $display("FAIL zero_len done_cycle: got %0d want 1", dc); end
      n_cmp++; if (ed !== 1'b0) begin n_bad++; $display("FAIL zero_len error: got %b want 0", ed); end
      n_cmp++; if (wr_addr_q.size() != 0) begin n_bad++; $display("FAIL zero_len writes: got %0d want 0", wr_addr_q.size()); end
      n_cmp++; if (ca !== 1'b0) begin n_bad++; $display("FAIL zero_len cpu_rst_after: got %b want 0", ca); end
      $display("zero_len: done at cycle %0d error=%b", dc, ed);
   endtask

   task automatic test_gaps();
      int dc; logic ed, cd, ca;
      logic [31:0] ref_a[$], ref_d[$];
      model_words.delete();
      repeat (3) model_words.push_back($urandom);
      build_stream();
      run_load(3, 0, 0, dc, ed, cd, ca);
      ref_a = wr_addr_q;
      ref_d = wr_data_q;
      n_cmp++; if (dc != 16 + CHK) begin n_bad++; $display("FAIL gaps nogap_done_cycle: got %0d want %0d", dc, 16 + CHK); end
      run_load(3, 50, 0, dc, ed, cd, ca);
      n_cmp++; if (wr_addr_q.size() != 3 || ref_a.size() != 3) begin n_bad++; $display("FAIL gaps write_count: gap %0d nogap %0d want 3", wr_addr_q.size(), ref_a.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++; if (wr_addr_q[i] !== BASE + 32'(4 * i) || wr_data_q[i] !== model_words[i]) begin n_bad++; $display("FAIL gaps write%0d: got (%h,%h) want (%h,%h)", i, wr_addr_q[i], wr_data_q[i], BASE + 32'(4 * i), model_words[i]); end
            n_cmp++; if (wr_addr_q[i] !== ref_a[i] || wr_data_q[i] !== ref_d[i]) begin n_bad++; $display("FAIL gaps vs_nogap%0d: got (%h,%h) nogap (%h,%h)", i, wr_addr_q[i], wr_data_q[i], ref_a[i], ref_d[i]); end
         end
      end
      n_cmp++; if (ready_viol != 0) begin n_bad++; $display("FAIL gaps in_ready_in_write: got %0d want 0", ready_viol); end
      n_cmp++; if (ed !== 1'b0 || ca !== 1'b0) begin n_bad++; $display("FAIL gaps status: error %b cpu_rst_after %b want 0/0", ed, ca); end
      $display("gaps: 3-word load with gaps done at cycle %0d", dc);
   endtask

   task automatic test_reset_mid();
      int dc; logic ed, cd, ca;
      int acc = 0;
      int guard = 0;
      bit pend;
      model_words.delete();
      repeat (2) model_words.push_back($urandom);
      build_stream();
      @(negedge clk);
      start_i = 1'b1;
      load_len_i = 8'd2;
      bus.in_valid = 1'b1;
      bus.in_data = stim_q[0];
      pend = bus.in_ready;
      while (acc < 6 && guard < 100) begin
         @(negedge clk);
         start_i = 1'b0;
         guard++;
         if (pend) acc++;
         bus.in_data = stim_q[acc];
         bus.in_valid = (acc < 6);
         pend = bus.in_valid && bus.in_ready;
      end
      n_cmp++; if (acc != 6 || busy_o !== 1'b1) begin n_bad++; $display("FAIL reset_mid feed: accepted %0d busy %b want 6/1", acc, busy_o); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (bus.initialize !== 1'b0 || busy_o !== 1'b0 || cpu_rst_o !== 1'b1) begin n_bad++; $display("FAIL reset_mid outputs: init %b busy %b cpu_rst %b want 0/0/1", bus.initialize, busy_o, cpu_rst_o); end
      n_cmp++; if (bus.in_ready !== 1'b0 || bus.instruction_initialize_data !== 32'h0) begin n_bad++; $display("FAIL reset_mid datapath: in_ready %b data %h want 0/0", bus.in_ready, bus.instruction_initialize_data); end
      @(negedge clk);
      rst = 1'b0;
      model_words.delete();
      model_words.push_back($urandom);
      build_stream();
      run_load(1, 20, 0, dc, ed, cd, ca);
      n_cmp++; if (wr_addr_q.size() != 1) begin n_bad++; $display("FAIL reset_mid reload_count: got %0d want 1", wr_addr_q.size()); end
      else begin
         n_cmp++; if (wr_addr_q[0] !== BASE || wr_data_q[0] !== model_words[0]) begin n_bad++; $display("FAIL reset_mid reload_write: got (%h,%h) want (%h,%h)", wr_addr_q[0], wr_data_q[0], BASE, model_words[0]); end
      end
      $display("reset_mid: reset after 6 bytes, reload done at cycle %0d", dc);
   endtask

   task automatic test_back_to_back();
      int dc; logic ed, cd, ca;
      int len;
      for (int t = 0; t < 5; t++) begin
         len = $urandom_range(6, 1);
         model_words.delete();
         repeat (len) model_words.push_back($urandom);
         build_stream();
         run_load(len, 30, 1, dc, ed, cd, ca);
         n_cmp++; if (wr_addr_q.size() != len) begin n_bad++; $display("FAIL b2b%0d write_count: got %0d want %0d", t, wr_addr_q.size(), len); end
         else begin
            for (int i = 0; i < len; i++) begin
               n_cmp++; if (wr_addr_q[i] !== BASE + 32'(4 * i) || wr_data_q[i] !== model_words[i]) begin n_bad++; $display("FAIL b2b%0d write%0d: got (%h,%h) want (%h,%h)", t, i, wr_addr_q[i], wr_data_q[i], BASE + 32'(4 * i), model_words[i]); end
            end
         end
         n_cmp++; if (ed !== 1'b0 || ca !== 1'b0 || ready_viol != 0) begin n_bad++; $display("FAIL b2b%0d status: error %b cpu_rst_after %b ready_viol %0d want 0/0/0", t, ed, ca, ready_viol); end
         $display("back_to_back %0d: len=%0d writes=%0d done at cycle %0d", t, len, wr_addr_q.size(), dc);
      end
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum();
      int dc; logic ed, cd, ca;
      stim_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
      run_load(1, 0, 0, dc, ed, cd, ca);
      n_cmp++; if (ed !== 1'b0 || ca !== 1'b0) begin n_bad++; $display("FAIL checksum good: error %b cpu_rst_after %b want 0/0", ed, ca); end
      stim_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
      run_load(1, 0, 0, dc, ed, cd, ca);
      n_cmp++; if (ed !== 1'b1 || ca !== 1'b1) begin n_bad++; $display("FAIL checksum bad: error %b cpu_rst_after %b want 1/1", ed, ca); end
      n_cmp++; if (wr_data_q.size() != 1 || wr_data_q[0] !== 32'h08040201) begin n_bad++; $display("FAIL checksum write: count %0d", wr_data_q.size()); end
      $display("checksum: good and bad trailing byte loads");
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_too_long();
      test_zero_len();
      test_gaps();
      test_reset_mid();
      test_back_to_back();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
